// File: rtl/hub75_scan_engine.sv
// hub75_scan_engine: HUB75 panel driver combining column shift, bit-plane
// display timing and row sequencing. It reads pixels from a memory that has
// one cycle of read latency.
// Optional feature macro: HUB75_SWAP_EN enables the double-buffer frame-swap
// handshake (i_swap_req / o_swap_ack). When it is undefined, buffer select is
// fixed at 0.
module hub75_scan_engine #(
  parameter int HPIXEL       = 64,
  parameter int VPIXEL       = 64,
  parameter int BPP          = 8,
  parameter int SEGMENTS     = 2,
  parameter int CLK_DIV_WD   = 8,
  parameter int BASE_WAIT_WD = 16,
  localparam int ROWS        = VPIXEL / SEGMENTS,
  localparam int ROW_WD      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int ADDR_WD     = $clog2(HPIXEL * ROWS) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic [CLK_DIV_WD-1:0]       i_clk_div,
  input  logic [BASE_WAIT_WD-1:0]     i_base_wait,
  input  logic [7:0]                  i_blank,
  input  logic [7:0]                  i_brightness,
  input  logic                        i_swap_req,
  output logic [ADDR_WD-1:0]          o_rd_addr,
  input  logic [SEGMENTS*3*BPP-1:0]   i_rd_data,
  output logic                        O_CLK,
  output logic                        STB,
  output logic                        OE,
  output logic [ROW_WD-1:0]           o_row,
  output logic [SEGMENTS-1:0]         o_r,
  output logic [SEGMENTS-1:0]         o_g,
  output logic [SEGMENTS-1:0]         o_b,
  output logic                        o_frame_done,
  output logic                        o_swap_ack
);

  localparam int LA_WD  = ADDR_WD - 1;
  localparam int COL_WD = (HPIXEL > 1) ? $clog2(HPIXEL) : 1;
  localparam int BIT_WD = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int OT_WD  = BASE_WAIT_WD + BPP + 8;
  localparam int DC_WD  = BASE_WAIT_WD + BPP;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WAIT, S_BLANK_PRE, S_LATCH, S_BLANK_POST
  } state_t;

  state_t                  state;
  logic [CLK_DIV_WD-1:0]   div_r;
  logic [CLK_DIV_WD-1:0]   pcnt;
  logic [BASE_WAIT_WD-1:0] bw_r;
  logic [7:0]              blank_r;
  logic [7:0]              bright_r;
  logic [7:0]              blk_cnt;
  logic [COL_WD-1:0]       col;
  logic [BIT_WD-1:0]       bit_r;
  logic [ROW_WD-1:0]       row_r;
  logic                    buf_sel;
  logic [DC_WD-1:0]        disp_cnt;
  logic [DC_WD-1:0]        ontime_r;

  logic [CLK_DIV_WD-1:0]   div_eff;
  logic [7:0]              blank_eff;
  logic [OT_WD-1:0]        ot_full;
  logic [DC_WD-1:0]        ontime_calc;
  logic [DC_WD-1:0]        disp_dec;
  logic                    last_bit;
  logic                    last_row;
  logic [ROW_WD-1:0]       nrow;
  logic                    swap_now;
  logic                    enter_shift;
  logic [LA_WD-1:0]        addr_col_next;
  logic [LA_WD-1:0]        addr_row_start;
  logic [SEGMENTS-1:0]     px_r;
  logic [SEGMENTS-1:0]     px_g;
  logic [SEGMENTS-1:0]     px_b;

  // Select the current bit-plane for each segment and colour from the memory word.
  for (genvar s = 0; s < SEGMENTS; s++) begin : g_seg
    logic [BPP-1:0] r_pl, g_pl, b_pl;
    assign r_pl    = i_rd_data[s*3*BPP + 2*BPP +: BPP];
    assign g_pl    = i_rd_data[s*3*BPP + BPP   +: BPP];
    assign b_pl    = i_rd_data[s*3*BPP         +: BPP];
    assign px_r[s] = r_pl[bit_r];
    assign px_g[s] = g_pl[bit_r];
    assign px_b[s] = b_pl[bit_r];
  end

  // Clamp the runtime settings, compute the on-time, and determine the next plane.
  always_comb begin
    div_eff     = (i_clk_div < CLK_DIV_WD'(2)) ? CLK_DIV_WD'(2) : i_clk_div;
    blank_eff   = (i_blank == 8'd0) ? 8'd1 : i_blank;
    ot_full     = (OT_WD'(bw_r) << bit_r) * OT_WD'(bright_r);
    ontime_calc = DC_WD'(ot_full >> 8);
    disp_dec    = (disp_cnt == '0) ? '0 : disp_cnt - 1'b1;
    last_bit    = (bit_r == BIT_WD'(BPP - 1));
    last_row    = (row_r == ROW_WD'(ROWS - 1));
    nrow        = row_r;
    if (last_bit) nrow = last_row ? '0 : row_r + 1'b1;
`ifdef HUB75_SWAP_EN
    swap_now    = last_bit && last_row && i_swap_req;
`else
    swap_now    = 1'b0;
`endif
    enter_shift = i_enable &&
                  ((state == S_IDLE) || (state == S_BLANK_POST && blk_cnt == 8'd0));
    addr_col_next  = LA_WD'(int'(row_r) * HPIXEL + int'(col) + 1);
    addr_row_start = LA_WD'(int'(nrow) * HPIXEL);
  end

`ifndef HUB75_SWAP_EN
  logic unused_swap_req;
  assign unused_swap_req = i_swap_req;
`endif

  // Capture the timing settings each time a plane shift begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r    <= CLK_DIV_WD'(2);
      bw_r     <= '0;
      blank_r  <= 8'd1;
      bright_r <= '0;
    end else if (enter_shift) begin
      div_r    <= div_eff;
      bw_r     <= i_base_wait;
      blank_r  <= blank_eff;
      bright_r <= i_brightness;
    end
  end

  // Scan FSM. The display timer runs alongside the shift of the next plane.
  // o_rd_addr always holds the next column to fetch. Because of this, the data
  // for a column is already valid in low-phase cycle 0, and it is registered
  // out to the panel at the end of that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      O_CLK        <= 1'b0;
      STB          <= 1'b0;
      OE           <= 1'b1;
      o_row        <= '0;
      o_r          <= '0;
      o_g          <= '0;
      o_b          <= '0;
      o_rd_addr    <= '0;
      o_frame_done <= 1'b0;
      o_swap_ack   <= 1'b0;
      pcnt         <= '0;
      col          <= '0;
      bit_r        <= '0;
      row_r        <= '0;
      buf_sel      <= 1'b0;
      blk_cnt      <= '0;
      disp_cnt     <= '0;
      ontime_r     <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_swap_ack   <= 1'b0;
      STB          <= 1'b0;
      disp_cnt     <= disp_dec;
      OE           <= (disp_dec == '0);
      case (state)
        S_IDLE: begin
          O_CLK <= 1'b0;
          if (i_enable) state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (!O_CLK && pcnt == '0) begin
            o_r <= px_r;
            o_g <= px_g;
            o_b <= px_b;
            if (col != COL_WD'(HPIXEL - 1)) o_rd_addr <= {buf_sel, addr_col_next};
          end
          if (pcnt == div_r - 1'b1) begin
            pcnt  <= '0;
            O_CLK <= ~O_CLK;
            if (O_CLK) begin
              if (col == COL_WD'(HPIXEL - 1)) state <= S_WAIT;
              else col <= col + 1'b1;
            end
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (disp_cnt == '0) begin
            state   <= S_BLANK_PRE;
            blk_cnt <= blank_r - 8'd1;
          end
        end
        S_BLANK_PRE: begin
          if (blk_cnt == 8'd0) begin
            state    <= S_LATCH;
            STB      <= 1'b1;
            o_row    <= row_r;
            ontime_r <= ontime_calc;
          end else begin
            blk_cnt <= blk_cnt - 8'd1;
          end
        end
        S_LATCH: begin
          state     <= S_BLANK_POST;
          blk_cnt   <= blank_r - 8'd1;
          bit_r     <= last_bit ? '0 : bit_r + 1'b1;
          row_r     <= nrow;
          buf_sel   <= buf_sel ^ swap_now;
          o_rd_addr <= {buf_sel ^ swap_now, addr_row_start};
          if (last_bit && last_row) o_frame_done <= 1'b1;
          o_swap_ack <= swap_now;
        end
        S_BLANK_POST: begin
          if (blk_cnt == 8'd0) begin
            disp_cnt <= ontime_r;
            OE       <= (ontime_r == '0);
            state    <= i_enable ? S_SHIFT : S_IDLE;
          end else begin
            blk_cnt <= blk_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (enter_shift) begin
        pcnt <= '0;
        col  <= '0;
      end
    end
  end

endmodule
